// File: rtl/goto_lookup_engine_if.sv
// Lookup request/response bundle between the matcher controller and the goto engine.
interface goto_lookup_engine_if #(
  parameter int STATE_W = 8,
  parameter int CHAR_W  = 4,
  parameter int ADDR_W  = 5
);
  logic               REQ_VALID;
  logic               REQ_READY;
  logic [STATE_W-1:0] REQ_STATE;
  logic [CHAR_W-1:0]  REQ_CHAR;
  logic               RSP_VALID;
  logic               RSP_READY;
  logic               RSP_HIT;
  logic               RSP_FAIL;
  logic [STATE_W-1:0] RSP_NEXT;
  logic [ADDR_W-1:0]  RSP_IDX;

  // Requester side (matcher controller)
  modport master (
    output REQ_VALID, REQ_STATE, REQ_CHAR, RSP_READY,
    input  REQ_READY, RSP_VALID, RSP_HIT, RSP_FAIL, RSP_NEXT, RSP_IDX
  );

  // Engine side
  modport slave (
    input  REQ_VALID, REQ_STATE, REQ_CHAR, RSP_READY,
    output REQ_READY, RSP_VALID, RSP_HIT, RSP_FAIL, RSP_NEXT, RSP_IDX
  );
endinterface

// File: rtl/goto_lookup_engine.sv
// Aho-Corasick goto-function lookup engine: writable (state,char)->next table,
// scanned one entry per cycle for the first valid match.
module goto_lookup_engine #(
  parameter  int STATE_W = 8,
  parameter  int CHAR_W  = 4,
  parameter  int DEPTH   = 32,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               WR_EN,
  input  logic [ADDR_W-1:0]  WR_ADDR,
  input  logic [STATE_W-1:0] WR_STATE,
  input  logic [CHAR_W-1:0]  WR_CHAR,
  input  logic [STATE_W-1:0] WR_NEXT,
  input  logic               WR_VLD,
  input  logic               CLR,
  goto_lookup_engine_if.slave bus,
  output logic               BUSY
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_RESP} state_t;

  state_t r_state, w_state_nxt;

  // Table storage; only the valid bits carry reset
  logic [STATE_W-1:0] r_tab_state [DEPTH];
  logic [CHAR_W-1:0]  r_tab_char  [DEPTH];
  logic [STATE_W-1:0] r_tab_next  [DEPTH];
  logic [DEPTH-1:0]   r_tab_vld;

  // Latched lookup key and scan pointer
  logic [STATE_W-1:0] r_key_state;
  logic [CHAR_W-1:0]  r_key_char;
  logic [ADDR_W-1:0]  r_idx;

  // Registered response
  logic               r_rsp_hit;
  logic               r_rsp_fail;
  logic [STATE_W-1:0] r_rsp_next;
  logic [ADDR_W-1:0]  r_rsp_idx;

  logic w_match;
  logic w_last;
  logic w_accept;

  assign w_match  = r_tab_vld[r_idx] &&
                    (r_tab_state[r_idx] == r_key_state) &&
                    (r_tab_char[r_idx]  == r_key_char);
  assign w_last   = (r_idx == ADDR_W'(DEPTH-1));
  assign w_accept = (r_state == S_IDLE) && bus.REQ_VALID;

  // Entry fields: written whenever WR_EN, no reset (contents undefined until written)
  always_ff @(posedge CLK) begin
    if (WR_EN) begin
      r_tab_state[WR_ADDR] <= WR_STATE;
      r_tab_char[WR_ADDR]  <= WR_CHAR;
      r_tab_next[WR_ADDR]  <= WR_NEXT;
    end
  end

  // Valid bits: reset/CLR invalidate all, a same-cycle write overrides CLR for its entry
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tab_vld <= '0;
    end else begin
      if (CLR)   r_tab_vld <= '0;
      if (WR_EN) r_tab_vld[WR_ADDR] <= WR_VLD;
    end
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.REQ_VALID)       w_state_nxt = S_SCAN;
      S_SCAN:  if (w_match || w_last)   w_state_nxt = S_RESP;
      S_RESP:  if (bus.RSP_READY)       w_state_nxt = S_IDLE;
      default:                          w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: handshake flags decode straight from the state register
  always_comb begin
    bus.REQ_READY = (r_state == S_IDLE);
    bus.RSP_VALID = (r_state == S_RESP);
    BUSY          = (r_state != S_IDLE);
    bus.RSP_HIT   = r_rsp_hit;
    bus.RSP_FAIL  = r_rsp_fail;
    bus.RSP_NEXT  = r_rsp_next;
    bus.RSP_IDX   = r_rsp_idx;
  end

  // Key capture on accept; key is only meaningful while scanning, so no reset
  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_key_state <= bus.REQ_STATE;
      r_key_char  <= bus.REQ_CHAR;
    end
  end

  // Scan pointer: restart at 0 on accept, step while scanning without a result
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_idx <= '0;
    end else if (w_accept) begin
      r_idx <= '0;
    end else if ((r_state == S_SCAN) && !w_match && !w_last) begin
      r_idx <= r_idx + ADDR_W'(1);
    end
  end

  // Response registers: loaded only on the SCAN->RESP transition, so they hold through RESP
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rsp_hit  <= 1'b0;
      r_rsp_fail <= 1'b0;
      r_rsp_next <= '0;
      r_rsp_idx  <= '0;
    end else if (r_state == S_SCAN) begin
      if (w_match) begin
        r_rsp_hit  <= 1'b1;
        r_rsp_fail <= 1'b0;
        r_rsp_next <= r_tab_next[r_idx];
        r_rsp_idx  <= r_idx;
      end else if (w_last) begin
        // Miss from root is a self-loop; any other state must follow its failure link
        r_rsp_hit  <= 1'b0;
        r_rsp_fail <= (r_key_state != '0);
        r_rsp_next <= '0;
        r_rsp_idx  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_goto_lookup_engine.sv
// Bench for goto_lookup_engine: directed vector table, multi-cycle corner sequences,
// and random table/lookup traffic against a first-match reference model.
module tb_goto_lookup_engine;
  localparam int SW = 8;
  localparam int CW = 4;
  localparam int D  = 32;
  localparam int AW = 5;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          WR_EN = 1'b0;
  logic [AW-1:0] WR_ADDR = '0;
  logic [SW-1:0] WR_STATE = '0;
  logic [CW-1:0] WR_CHAR = '0;
  logic [SW-1:0] WR_NEXT = '0;
  logic          WR_VLD = 1'b0;
  logic          CLR = 1'b0;
  logic          BUSY;

  int n_chk = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  goto_lookup_engine_if #(.STATE_W(SW), .CHAR_W(CW), .ADDR_W(AW)) bus();

  goto_lookup_engine #(.STATE_W(SW), .CHAR_W(CW), .DEPTH(D)) dut (
    .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_STATE(WR_STATE),
    .WR_CHAR(WR_CHAR), .WR_NEXT(WR_NEXT), .WR_VLD(WR_VLD), .CLR(CLR),
    .bus(bus), .BUSY(BUSY)
  );

  // Reference table: a plain list of entries
  logic [SW-1:0] m_st [D];
  logic [CW-1:0] m_ch [D];
  logic [SW-1:0] m_nx [D];
  bit            m_v  [D];

  typedef struct {
    logic [SW-1:0] s;
    logic [CW-1:0] c;
    logic          hit;
    logic          fail;
    logic [SW-1:0] nx;
    logic [AW-1:0] idx;
    int            lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < D; i++) m_v[i] = 1'b0;
  endfunction

  // First valid entry with the key, by ascending index; miss costs a full sweep
  function automatic void ref_lookup(input logic [SW-1:0] s, input logic [CW-1:0] c,
                                     output vec_t r);
    r.s = s; r.c = c; r.hit = 1'b0; r.fail = (s != 0); r.nx = '0; r.idx = '0; r.lat = D;
    for (int i = 0; i < D; i++) begin
      if (m_v[i] && m_st[i] == s && m_ch[i] == c) begin
        r.hit = 1'b1; r.fail = 1'b0; r.nx = m_nx[i]; r.idx = AW'(i); r.lat = i + 1;
        break;
      end
    end
  endfunction

  task automatic wr(input int a, input int s, input int c, input int n, input bit v);
    @(negedge CLK);
    WR_EN = 1'b1; WR_ADDR = AW'(a); WR_STATE = SW'(s); WR_CHAR = CW'(c);
    WR_NEXT = SW'(n); WR_VLD = v;
    @(negedge CLK);
    WR_EN = 1'b0;
    m_st[a] = SW'(s); m_ch[a] = CW'(c); m_nx[a] = SW'(n); m_v[a] = v;
  endtask

  task automatic clr_all();
    @(negedge CLK); CLR = 1'b1;
    @(negedge CLK); CLR = 1'b0;
    model_clear();
  endtask

  // Wait for RSP_VALID at negedges, counting edges since accept; bounded
  task automatic wait_rsp(inout int lat);
    while (!bus.RSP_VALID && lat < 100) begin
      @(negedge CLK); lat++;
    end
    if (!bus.RSP_VALID) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  // One full lookup transaction, compared against an expected record
  task automatic lookup(input string nm, input vec_t e);
    int lat;
    @(negedge CLK);
    chk({nm, "_req_ready"}, bus.REQ_READY, 1);
    bus.REQ_VALID = 1'b1; bus.REQ_STATE = e.s; bus.REQ_CHAR = e.c;
    @(negedge CLK);
    bus.REQ_VALID = 1'b0;
    chk({nm, "_busy"}, {BUSY, bus.REQ_READY}, 2'b10);
    lat = 0;
    wait_rsp(lat);
    chk({nm, "_lat"}, lat, e.lat);
    chk({nm, "_hit"}, bus.RSP_HIT, e.hit);
    chk({nm, "_fail"}, bus.RSP_FAIL, e.fail);
    chk({nm, "_next"}, bus.RSP_NEXT, e.nx);
    chk({nm, "_idx"}, bus.RSP_IDX, e.idx);
    bus.RSP_READY = 1'b1;
    @(negedge CLK);
    bus.RSP_READY = 1'b0;
    chk({nm, "_done"}, {bus.RSP_VALID, bus.REQ_READY}, 2'b01);
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_outs"},
        {bus.REQ_READY, bus.RSP_VALID, bus.RSP_HIT, bus.RSP_FAIL, BUSY},
        5'b10000);
    chk({nm, "_next"}, bus.RSP_NEXT, 0);
    chk({nm, "_idx"}, bus.RSP_IDX, 0);
  endtask

  vec_t vt [5];
  vec_t e;
  int   lat;
  logic [SW-1:0] h_next;
  logic [AW-1:0] h_idx;

  initial begin
    bus.REQ_VALID = 1'b0; bus.REQ_STATE = '0; bus.REQ_CHAR = '0; bus.RSP_READY = 1'b0;
    model_clear();

    vt[0] = '{s:8'd1, c:4'd2, hit:1'b1, fail:1'b0, nx:8'd2, idx:5'd1, lat:2};
    vt[1] = '{s:8'd2, c:4'd3, hit:1'b1, fail:1'b0, nx:8'd3, idx:5'd5, lat:6};
    vt[2] = '{s:8'd0, c:4'd7, hit:1'b0, fail:1'b0, nx:8'd0, idx:5'd0, lat:32};
    vt[3] = '{s:8'd2, c:4'd9, hit:1'b0, fail:1'b1, nx:8'd0, idx:5'd0, lat:32};
    vt[4] = '{s:8'd0, c:4'd1, hit:1'b1, fail:1'b0, nx:8'd1, idx:5'd0, lat:1};

    // Reset state, held and released
    repeat (3) @(negedge CLK);
    chk_reset_outs("rst_hold");
    RST = 1'b0;
    @(negedge CLK);
    chk_reset_outs("rst_rel");

    // Directed table
    wr(0, 0, 1, 1, 1'b1);
    wr(1, 1, 2, 2, 1'b1);
    wr(5, 2, 3, 3, 1'b1);
    for (int i = 0; i < 5; i++) lookup($sformatf("vec%0d", i), vt[i]);

    // Backpressure: response held 10 cycles, new request ignored
    @(negedge CLK);
    bus.REQ_VALID = 1'b1; bus.REQ_STATE = 8'd2; bus.REQ_CHAR = 4'd3;
    @(negedge CLK);
    bus.REQ_VALID = 1'b0;
    lat = 0;
    wait_rsp(lat);
    h_next = bus.RSP_NEXT; h_idx = bus.RSP_IDX;
    chk("hold_first", {bus.RSP_HIT, h_next, h_idx}, {1'b1, 8'd3, 5'd5});
    bus.REQ_VALID = 1'b1; bus.REQ_STATE = 8'd0; bus.REQ_CHAR = 4'd1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk($sformatf("hold_c%0d", i),
          {bus.RSP_VALID, bus.REQ_READY, bus.RSP_HIT, bus.RSP_FAIL, bus.RSP_NEXT, bus.RSP_IDX},
          {1'b1, 1'b0, 1'b1, 1'b0, 8'd3, 5'd5});
    end
    bus.RSP_READY = 1'b1; bus.REQ_VALID = 1'b0;
    @(negedge CLK);
    bus.RSP_READY = 1'b0;
    chk("hold_release", {bus.RSP_VALID, bus.REQ_READY}, 2'b01);
    @(negedge CLK);
    chk("hold_no_queue", {BUSY, bus.REQ_READY}, 2'b01);

    // Duplicate keys: lowest index wins, deletion exposes the next one
    clr_all();
    wr(3, 1, 2, 9, 1'b1);
    wr(7, 1, 2, 4, 1'b1);
    lookup("dup", '{s:8'd1, c:4'd2, hit:1'b1, fail:1'b0, nx:8'd9, idx:5'd3, lat:4});
    wr(3, 1, 2, 9, 1'b0);
    lookup("dup_del", '{s:8'd1, c:4'd2, hit:1'b1, fail:1'b0, nx:8'd4, idx:5'd7, lat:8});

    // Mid-scan CLR with a simultaneous write of a later entry
    clr_all();
    wr(1, 1, 2, 2, 1'b1);
    wr(10, 1, 2, 7, 1'b1);
    @(negedge CLK);
    bus.REQ_VALID = 1'b1; bus.REQ_STATE = 8'd1; bus.REQ_CHAR = 4'd2;
    @(negedge CLK);
    bus.REQ_VALID = 1'b0;
    CLR = 1'b1; WR_EN = 1'b1; WR_ADDR = 5'd20; WR_STATE = 8'd1; WR_CHAR = 4'd2;
    WR_NEXT = 8'd6; WR_VLD = 1'b1;
    @(negedge CLK);
    CLR = 1'b0; WR_EN = 1'b0;
    model_clear();
    m_st[20] = 8'd1; m_ch[20] = 4'd2; m_nx[20] = 8'd6; m_v[20] = 1'b1;
    lat = 1;
    wait_rsp(lat);
    chk("midclr_lat", lat, 21);
    chk("midclr_rsp", {bus.RSP_HIT, bus.RSP_FAIL, bus.RSP_NEXT, bus.RSP_IDX},
        {1'b1, 1'b0, 8'd6, 5'd20});
    bus.RSP_READY = 1'b1;
    @(negedge CLK);
    bus.RSP_READY = 1'b0;

    // Random table edits and lookups against the model
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 1) == 0)
        wr($urandom_range(0, D-1), $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(1, 255), $urandom_range(0, 3) != 0);
      ref_lookup(SW'($urandom_range(0, 3)), CW'($urandom_range(0, 3)), e);
      lookup($sformatf("rnd%0d", r), e);
    end

    // Reset during SCAN: nothing returned, table emptied
    wr(25, 1, 2, 8, 1'b1);
    @(negedge CLK);
    bus.REQ_VALID = 1'b1; bus.REQ_STATE = 8'd1; bus.REQ_CHAR = 4'd2;
    @(negedge CLK);
    bus.REQ_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk_reset_outs("scan_rst");
    RST = 1'b0;
    model_clear();
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (bus.RSP_VALID) chk("scan_rst_norsp", 32'd1, 32'd0);
    end
    ref_lookup(8'd1, 4'd2, e);
    chk("scan_rst_model_miss", e.fail, 1);
    lookup("after_rst", e);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/goto_lookup_engine.md
# goto_lookup_engine

Parametrised Aho-Corasick goto-function lookup engine: a writable transition table of (current state, character) -> next state entries, with a valid bit per entry and a request/response lookup port. The engine scans the table sequentially for the first valid entry matching the requested state and character. It returns hit/next-state, or a miss classified as root self-loop or failure-follow. It sits between the matcher controller and the failure-function block, replacing the fixed 32-entry, read-only goto memory.

## Interface
- STATE_W, 8, state identifier width
- CHAR_W, 4, input character (symbol) width
- DEPTH, 32, number of table entries; must be at least 2
- ADDR_W, $clog2(DEPTH), entry index width (derived, not overridden)

- CLK  in  1  clock, all logic on posedge
- RST  in  1  reset, synchronous, active-high
- WR_EN  in  1  write one table entry this cycle
- WR_ADDR  in  ADDR_W  entry index to write
- WR_STATE  in  STATE_W  entry current-state field
- WR_CHAR  in  CHAR_W  entry character field
- WR_NEXT  in  STATE_W  entry next-state field
- WR_VLD  in  1  valid bit written with the entry (0 = delete entry)
- CLR  in  1  invalidate all entries
- REQ_VALID  in  1  lookup request present
- REQ_READY  out  1  engine accepts a request
- REQ_STATE  in  STATE_W  current state to look up
- REQ_CHAR  in  CHAR_W  character to look up
- RSP_VALID  out  1  response present
- RSP_READY  in  1  consumer accepts response
- RSP_HIT  out  1  matching entry found
- RSP_FAIL  out  1  miss with REQ_STATE != 0; controller must follow the failure link
- RSP_NEXT  out  STATE_W  next state; 0 on any miss
- RSP_IDX  out  ADDR_W  index of the matching entry; 0 on a miss
- BUSY  out  1  FSM not in IDLE

## Operation
- Storage: per-entry registers state[STATE_W], char[CHAR_W], next[STATE_W] and vld. Only vld is reset. Field contents are undefined until written.
- Write port is independent of the FSM and is legal in any cycle. Written data is visible to compares from the following cycle.
- CLR clears every vld at the edge. If CLR and WR_EN occur together, the write wins for WR_ADDR (vld <= WR_VLD) and all other entries are cleared.
- FSM states: IDLE, SCAN, RESP.
- IDLE: REQ_READY = 1. When REQ_VALID=1, latch REQ_STATE/REQ_CHAR, set idx <= 0, go to SCAN.
- SCAN: compare entry[idx]; a match is vld && state == latched state && char == latched char.
  - Match: go to RESP with HIT=1, NEXT=entry.next, IDX=idx, FAIL=0.
  - No match and idx == DEPTH-1: go to RESP with HIT=0, NEXT=0, IDX=0, FAIL = (latched state != 0).
  - Otherwise: idx <= idx+1.
- First match by ascending index wins when duplicate keys exist.
- RESP: RSP_VALID = 1 and all response fields are held stable. When RSP_READY=1, go to IDLE.
- A miss from state 0 is the root self-loop: HIT=0, FAIL=0, NEXT=0.
- A compare in a cycle where the same entry is written uses the old contents.
- RST in any state forces IDLE, clears all vld bits and discards any in-flight lookup. No response is produced for it.

## Timing
- Reset values: REQ_READY=1 (IDLE), RSP_VALID=0, RSP_HIT=0, RSP_FAIL=0, RSP_NEXT=0, RSP_IDX=0, BUSY=0. The cycle after RST deasserts already accepts a request.
- Accept edge is E0. A match at entry k raises RSP_VALID after edge E(k+1), i.e. k+1 cycles of latency. A miss raises RSP_VALID after edge E(DEPTH).
- RSP_VALID falls on the edge where RSP_READY=1. REQ_READY rises in the same cycle, so the minimum request spacing is latency + 2 cycles.
- REQ_READY = 0 throughout SCAN and RESP. Requests are not queued.
- All response outputs are registered and change only on entry to RESP or on reset.

## Test plan
- Reset, then write entries {0,1->1}@0, {1,2->2}@1, {2,3->3}@5. Request (1,2) -> RSP_HIT=1, NEXT=2, IDX=1, RSP_VALID 2 cycles after accept.
- Same table, request (2,3) -> HIT=1, NEXT=3, IDX=5. Request (0,7) -> HIT=0, FAIL=0, NEXT=0 after 32 cycles. Request (2,9) -> HIT=0, FAIL=1, NEXT=0.
- Duplicate key (1,2) at index 3 (->9) and index 7 (->4) -> NEXT=9, IDX=3. Delete index 3 via WR_VLD=0, repeat -> NEXT=4, IDX=7.
- Hold RSP_READY=0 for 10 cycles -> RSP_VALID and all fields stable, REQ_READY=0, new REQ_VALID ignored. Release -> REQ_READY=1 in the next cycle.
- Mid-scan CLR with a simultaneous write of {1,2->6}@20 during a lookup for (1,2) -> HIT=1, NEXT=6, IDX=20. Any earlier-index match cleared before its compare is not reported.
- Assert RST during SCAN -> no RSP_VALID, outputs at reset values, all entries invalid, so a subsequent lookup of (1,2) misses with FAIL=1.
